// File: rtl/proc_control_unit.sv
// Instruction-sequencing FSM for the 16-bit simple processor: latches IR from din
// and drives the bus mux select, register/A/G load enables, ALU add/sub and done.
module proc_control_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [15:0] din,
    output logic [15:0] ir_out,
    output logic [3:0]  mux_sel,
    output logic [7:0]  r_in,
    output logic        a_in,
    output logic        g_in,
    output logic        addsub,
    output logic        done
);

    localparam logic [2:0] MV      = 3'b000;
    localparam logic [2:0] MVT     = 3'b001;
    localparam logic [2:0] ADD     = 3'b010;
    localparam logic [2:0] SUB     = 3'b011;
    localparam logic [3:0] SEL_IMM = 4'd8;
    localparam logic [3:0] SEL_G   = 4'd9;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    state_t      state;
    logic [15:0] ir;
    logic [2:0]  op;
    logic        imm;
    logic [2:0]  rx;
    logic [2:0]  ry;
    logic        is_arith;

    assign op       = ir[15:13];
    assign imm      = ir[12];
    assign rx       = ir[11:9];
    assign ry       = ir[2:0];
    assign is_arith = (op == ADD) || (op == SUB);
    assign ir_out   = ir;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= T0;
            ir    <= '0;
        end else begin
            case (state)
                T0: begin
                    if (run) begin
                        ir    <= din;
                        state <= T1;
                    end
                end
                T1:      state <= is_arith ? T2 : T0;
                T2:      state <= T3;
                T3:      state <= T0;
                default: state <= T0;
            endcase
        end
    end

    // Outputs are decoded from state and IR so reset clears every enable asynchronously.
    always_comb begin
        mux_sel = '0;
        r_in    = '0;
        a_in    = 1'b0;
        g_in    = 1'b0;
        addsub  = 1'b0;
        done    = 1'b0;
        case (state)
            T1: begin
                case (op)
                    MV: begin
                        mux_sel  = imm ? SEL_IMM : {1'b0, ry};
                        r_in[rx] = 1'b1;
                        done     = 1'b1;
                    end
                    MVT: begin
                        mux_sel  = SEL_IMM;
                        r_in[rx] = 1'b1;
                        done     = 1'b1;
                    end
                    ADD, SUB: begin
                        mux_sel = {1'b0, rx};
                        a_in    = 1'b1;
                    end
                    default: done = 1'b1;
                endcase
            end
            T2: begin
                mux_sel = imm ? SEL_IMM : {1'b0, ry};
                g_in    = 1'b1;
                addsub  = (op == SUB);
            end
            T3: begin
                mux_sel  = SEL_G;
                r_in[rx] = 1'b1;
                done     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_proc_control_unit.sv
// Directed scoreboard bench for proc_control_unit: expected output vectors are queued
// as each step is driven and popped/compared one time unit after the clock edge.
module tb_proc_control_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [15:0] din;
    logic [15:0] ir_out;
    logic [3:0]  mux_sel;
    logic [7:0]  r_in;
    logic        a_in;
    logic        g_in;
    logic        addsub;
    logic        done;

    int unsigned checks = 0;
    int unsigned errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] v;
    } exp_t;

    exp_t sb[$];

    proc_control_unit dut (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .din     (din),
        .ir_out  (ir_out),
        .mux_sel (mux_sel),
        .r_in    (r_in),
        .a_in    (a_in),
        .g_in    (g_in),
        .addsub  (addsub),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Vector layout: {ir[15:0], mux_sel[3:0], r_in[7:0], a_in, g_in, addsub, done}
    function automatic logic [31:0] mk(input logic [15:0] ir, input logic [3:0] sel,
                                       input logic [7:0] r, input logic a, input logic g,
                                       input logic as, input logic d);
        return {ir, sel, r, a, g, as, d};
    endfunction

    task automatic expect_out(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic check_now();
        exp_t        e;
        logic [31:0] obs;
        obs = {ir_out, mux_sel, r_in, a_in, g_in, addsub, done};
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.v) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        check_now();
    endtask

    initial begin
        rst = 1'b1;
        run = 1'b0;
        din = 16'h0000;
        #3;
        expect_out("reset_state", mk(16'h0000, 4'd0, 8'h00, 0, 0, 0, 0));
        check_now();
        rst = 1'b0;

        // mv r3,#0x1FF
        run = 1'b1; din = 16'h17FF;
        expect_out("mv_imm_t1", mk(16'h17FF, 4'd8, 8'h08, 0, 0, 0, 1)); cyc();
        run = 1'b0; din = 16'h0000;
        expect_out("mv_imm_t0", mk(16'h17FF, 4'd0, 8'h00, 0, 0, 0, 0)); cyc();

        // mv r1,r2
        run = 1'b1; din = 16'h0202;
        expect_out("mv_reg_t1", mk(16'h0202, 4'd2, 8'h02, 0, 0, 0, 1)); cyc();
        run = 1'b0;
        expect_out("mv_reg_t0", mk(16'h0202, 4'd0, 8'h00, 0, 0, 0, 0)); cyc();

        // add r0,r1
        run = 1'b1; din = 16'h4001;
        expect_out("add_t1", mk(16'h4001, 4'd0, 8'h00, 1, 0, 0, 0)); cyc();
        run = 1'b0; din = 16'hFFFF;
        expect_out("add_t2", mk(16'h4001, 4'd1, 8'h00, 0, 1, 0, 0)); cyc();
        expect_out("add_t3", mk(16'h4001, 4'd9, 8'h01, 0, 0, 0, 1)); cyc();
        expect_out("add_t0", mk(16'h4001, 4'd0, 8'h00, 0, 0, 0, 0)); cyc();

        // sub r5,#0x10 then mvt r7,#0xAB back-to-back with run held high
        run = 1'b1; din = 16'h7A10;
        expect_out("sub_t1", mk(16'h7A10, 4'd5, 8'h00, 1, 0, 0, 0)); cyc();
        din = 16'h3EAB;
        expect_out("sub_t2", mk(16'h7A10, 4'd8, 8'h00, 0, 1, 1, 0)); cyc();
        expect_out("sub_t3", mk(16'h7A10, 4'd9, 8'h20, 0, 0, 0, 1)); cyc();
        expect_out("sub_idle_t0", mk(16'h7A10, 4'd0, 8'h00, 0, 0, 0, 0)); cyc();
        expect_out("mvt_t1", mk(16'h3EAB, 4'd8, 8'h80, 0, 0, 0, 1)); cyc();
        run = 1'b0;
        expect_out("mvt_t0", mk(16'h3EAB, 4'd0, 8'h00, 0, 0, 0, 0)); cyc();

        // mvt r6 with imm flag clear still selects the immediate
        run = 1'b1; din = 16'h2C05;
        expect_out("mvt_noimm_t1", mk(16'h2C05, 4'd8, 8'h40, 0, 0, 0, 1)); cyc();
        run = 1'b0;
        expect_out("mvt_noimm_t0", mk(16'h2C05, 4'd0, 8'h00, 0, 0, 0, 0)); cyc();

        // NOP opcode
        run = 1'b1; din = 16'hE000;
        expect_out("nop_t1", mk(16'hE000, 4'd0, 8'h00, 0, 0, 0, 1)); cyc();
        run = 1'b0;
        expect_out("nop_t0", mk(16'hE000, 4'd0, 8'h00, 0, 0, 0, 0)); cyc();

        // add r2,r2 with run/din toggled during T1-T3
        run = 1'b1; din = 16'h4492;
        expect_out("gate_t1", mk(16'h4492, 4'd2, 8'h00, 1, 0, 0, 0)); cyc();
        run = 1'b0; din = 16'h1234;
        expect_out("gate_t2", mk(16'h4492, 4'd2, 8'h00, 0, 1, 0, 0)); cyc();
        run = 1'b1; din = 16'h5678;
        expect_out("gate_t3", mk(16'h4492, 4'd9, 8'h04, 0, 0, 0, 1)); cyc();
        run = 1'b0;
        expect_out("gate_t0", mk(16'h4492, 4'd0, 8'h00, 0, 0, 0, 0)); cyc();

        // sub r0,r1 interrupted by reset in T2
        run = 1'b1; din = 16'h6001;
        expect_out("rst_mid_t1", mk(16'h6001, 4'd0, 8'h00, 1, 0, 0, 0)); cyc();
        run = 1'b0;
        expect_out("rst_mid_t2", mk(16'h6001, 4'd1, 8'h00, 0, 1, 1, 0)); cyc();
        rst = 1'b1;
        #1;
        expect_out("rst_async", mk(16'h0000, 4'd0, 8'h00, 0, 0, 0, 0)); check_now();
        run = 1'b1; din = 16'hBEEF;
        expect_out("rst_held", mk(16'h0000, 4'd0, 8'h00, 0, 0, 0, 0)); cyc();

        // release with run=1: mv r5,r5 captured on the first edge
        rst = 1'b0; din = 16'h0A05;
        expect_out("rst_release_t1", mk(16'h0A05, 4'd5, 8'h20, 0, 0, 0, 1)); cyc();
        run = 1'b0;
        expect_out("rst_release_t0", mk(16'h0A05, 4'd0, 8'h00, 0, 0, 0, 0)); cyc();

        if (sb.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
